// File: rtl/sevenseg_scan_capture.sv
// Receive side of the multiplexed 7-segment bus: filters scan glitches, decodes
// settled segment patterns to symbol codes and assembles four positions into a frame.
module sevenseg_scan_capture #(
  parameter int unsigned STABLE  = 4,
  parameter logic [23:0] TIMEOUT = 24'd2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  DIGIT,
  input  logic [6:0]  DISPLAY,
  output logic [15:0] frame,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        bad_digit,
  output logic        stale
);
  typedef struct packed {
    logic [3:0] digit;
    logic [6:0] seg;
  } pair_t;

  // Undriven active-low lines read as a blanking gap, so that is the reset pair.
  localparam pair_t      IDLE    = '{digit: 4'hF, seg: 7'h7F};
  localparam logic [3:0] CNT_MAX = 4'(STABLE);
  localparam logic [3:0] CNT_ACC = 4'(STABLE - 2);
  localparam logic [23:0] TO_M1  = TIMEOUT - 24'd1;

  pair_t           s1, s2, prev;
  logic [3:0]      cnt;
  logic [3:0][3:0] slot;
  logic [3:0]      mask;
  logic [23:0]     idle;

  logic            same, accept, pos_ok, blank_dig, seg_bad, done;
  logic [1:0]      pos;
  logic [3:0]      code;
  logic [3:0][3:0] slot_nxt;
  logic [3:0]      mask_nxt;
  logic [23:0]     idle_nxt;

  // cnt holds the run length minus two, so the STABLE-th identical cycle accepts.
  assign same   = (s2 == prev);
  assign accept = same && (cnt == CNT_ACC);

  always_comb begin
    seg_bad = 1'b0;
    code    = 4'hF;
    case (s2.seg)
      7'b1000000: code = 4'd0;
      7'b1111001: code = 4'd1;
      7'b0100100: code = 4'd2;
      7'b0110000: code = 4'd3;
      7'b0011001: code = 4'd4;
      7'b0010010: code = 4'd5;
      7'b0000010: code = 4'd6;
      7'b1111000: code = 4'd7;
      7'b0000000: code = 4'd8;
      7'b0010000: code = 4'd9;
      7'b1011100: code = 4'd10;
      7'b1100011: code = 4'd11;
      7'b0001110: code = 4'd12;
      7'b1111111: code = 4'd14;
      default:    seg_bad = 1'b1;
    endcase
  end

  always_comb begin
    pos       = 2'd0;
    pos_ok    = 1'b0;
    blank_dig = 1'b0;
    case (s2.digit)
      4'b1110: begin pos = 2'd0; pos_ok = 1'b1; end
      4'b1101: begin pos = 2'd1; pos_ok = 1'b1; end
      4'b1011: begin pos = 2'd2; pos_ok = 1'b1; end
      4'b0111: begin pos = 2'd3; pos_ok = 1'b1; end
      4'b1111: blank_dig = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    slot_nxt = slot;
    mask_nxt = mask;
    if (accept && pos_ok) begin
      slot_nxt[pos] = code;
      mask_nxt      = mask | (4'b0001 << pos);
    end
    done = accept && pos_ok && (mask_nxt == 4'hF);
  end

  // idle_nxt counts edges since the accepting one; stale shows TIMEOUT cycles after it.
  always_comb begin
    idle_nxt = idle;
    if (accept)              idle_nxt = '0;
    else if (idle != TIMEOUT) idle_nxt = idle + 24'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= IDLE;
      s2          <= IDLE;
      prev        <= IDLE;
      cnt         <= '0;
      slot        <= {4{4'hE}};
      mask        <= '0;
      idle        <= '0;
      frame       <= 16'hEEEE;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      bad_digit   <= 1'b0;
      stale       <= 1'b1;
    end else begin
      s1          <= '{digit: DIGIT, seg: DISPLAY};
      s2          <= s1;
      prev        <= s2;
      cnt         <= !same ? 4'd0 : (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
      slot        <= slot_nxt;
      mask        <= done ? 4'h0 : mask_nxt;
      idle        <= idle_nxt;
      frame_valid <= done;
      seg_err     <= accept && pos_ok && seg_bad;
      bad_digit   <= accept && !pos_ok && !blank_dig;
      if (done) frame <= slot_nxt;
      if (done)                        stale <= 1'b0;
      else if (idle_nxt == TO_M1)      stale <= 1'b1;
    end
  end
endmodule

// File: doc/sevenseg_scan_capture.md
# sevenseg_scan_capture

Receiving end of the board's multiplexed 7-segment display bus. Samples the active-low digit-select (`DIGIT`) and segment (`DISPLAY`) lines produced by a display scanner and filters out scan-transition glitches. Decodes each settled segment pattern back to the team's 4-bit symbol code and assembles the four digit positions into one frame word. Used as an on-board self-checker and as a bench monitor for display-driving blocks.

## Interface
Parameters:
- `STABLE`, 4: consecutive cycles a DIGIT/DISPLAY pair must hold before acceptance (legal range 2..15).
- `TIMEOUT`, 24'd2_000_000: cycles without an accepted dwell before `stale` asserts.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `DIGIT`  in  4  anode selects, active-low; 4'b1110 is position 0 (rightmost).
- `DISPLAY`  in  7  segments {g,f,e,d,c,b,a}, active-low.
- `frame`  out  16  {pos3,pos2,pos1,pos0}, 4-bit symbol codes.
- `frame_valid`  out  1  one-cycle pulse when `frame` updates.
- `seg_err`  out  1  one-cycle pulse: accepted pattern is not in the decode table.
- `bad_digit`  out  1  one-cycle pulse: accepted DIGIT has more than one zero.
- `stale`  out  1  level: no accepted dwell for `TIMEOUT` cycles, or no frame since reset.

## Operation
- Input path: DIGIT and DISPLAY pass through 2 register stages (s1, s2). All decisions use s2.
- Stability filter:
  - A 4-bit counter clears when the s2 pair differs from the previous s2 pair.
  - Otherwise the counter increments, saturating at `STABLE`.
  - Acceptance happens exactly once per dwell, on the cycle the pair has been identical in s2 for `STABLE` consecutive cycles.
  - A dwell shorter than `STABLE` is discarded silently.
- DIGIT classification at acceptance:
  - Exactly one zero: valid position; write decoded symbol to that slot.
  - 4'b1111 (blanking gap): ignored, no error.
  - Any other value: `bad_digit` pulse; no slot write; mask unchanged.
- Segment decode table (codes):
  - Digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - 1011100 → 10 (UP); 1100011 → 11 (DOWN); 0001110 → 12 (F); 1111111 → 14 (blank).
  - Anything else → 15 with `seg_err` pulse; the slot is still written.
  - Code 13 (S) is never produced: its pattern equals digit 5 and decodes as 5.
- Frame assembly:
  - 4-bit seen-mask; each valid write sets its bit.
  - Rewriting an already-seen slot overwrites the slot and leaves the mask unchanged.
  - When a write completes mask 4'b1111, `frame` loads all four slots (including that write) and `frame_valid` pulses; the mask clears in the same cycle.
  - Frames need not arrive in scan order.
- Stale tracking:
  - A 24-bit idle counter clears on every acceptance (valid, blank or bad) and increments otherwise, saturating at `TIMEOUT`.
  - `stale` sets when the counter reaches `TIMEOUT`.
  - `stale` clears on `frame_valid` only.
- Reset mid-operation clears slots, mask, counters and all outputs; any partial frame is lost.

## Timing
- Reset values: `frame`=16'hEEEE, slots=4'hE, `frame_valid`=0, `seg_err`=0, `bad_digit`=0, `stale`=1, mask=0, counters=0.
- Latency: with a pair presented at the inputs in cycle t and held, s2 shows it at t+2.
  - Acceptance occurs at t+2+`STABLE`-1.
  - Slot write, `seg_err` and `bad_digit` are registered and visible at t+2+`STABLE`.
  - `frame` and `frame_valid` are visible in that same cycle.
- Minimum dwell for capture: `STABLE` cycles at the input pins.
- At most one acceptance per dwell; a dwell held indefinitely never re-accepts.
- `seg_err` and `frame_valid` may pulse in the same cycle.
- `stale` sets exactly `TIMEOUT` cycles after the last acceptance cycle.

## Test plan
- Reset: assert `rst` mid-frame, then release → `frame`=16'hEEEE, `stale`=1, `frame_valid`=0, mask cleared; a subsequent single-slot write gives no `frame_valid`.
- Clean scan (STABLE=4): hold each pair for 8 cycles:
  - 1110/0110000, then 1101/0100100, then 1011/1111001, then 0111/1011100.
  - Expect one `frame_valid`, `frame`=16'hA123, `stale`=0.
  - Pulse timing: 2+4 cycles after the last pair's start.
- Glitch rejection: hold 1110/0000000 for 3 cycles, then switch to 1110/1000000 for 8 cycles → slot0=0, never 8.
- Decode errors: 1110/0101010 held 8 cycles → `seg_err` single pulse, slot0=15.
  - Then 1110/0010010 → slot0=5 (S/5 alias).
- DIGIT errors: 1100/0000000 held 8 cycles → `bad_digit` pulse, no slot change.
  - 1111/any → no pulses, no slot change, idle counter cleared.
- Timeout (TIMEOUT=100): complete a frame, then hold one pair indefinitely → `stale` rises exactly 100 cycles after the last acceptance; the next completed frame clears it.
